// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for the FIR accelerator: loads taps and length over AXI-Lite, streams samples, polls for done.
// Optional feature: define FIR_HOST_CHECKSUM_EN to enable the running y_sum checksum of received outputs.
module fir_host_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   cmd_start,
   input  logic [pDATA_WIDTH-1:0] cmd_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [3:0]             coef_idx,
   input  logic [pDATA_WIDTH-1:0] coef_data,
   input  logic                   x_valid,
   output logic                   x_ready,
   input  logic [pDATA_WIDTH-1:0] x_data,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [pADDR_WIDTH-1:0] awaddr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [pDATA_WIDTH-1:0] wdata,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   ss_tvalid,
   input  logic                   ss_tready,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   sm_tvalid,
   output logic                   sm_tready,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   input  logic                   sm_tlast,
   output logic                   y_valid,
   output logic [pDATA_WIDTH-1:0] y_data,
   output logic [pDATA_WIDTH-1:0] y_sum
);

   typedef enum logic [2:0] {IDLE, WR_TAP, WR_LEN, WR_START, STREAM, POLL, DONE} state_t;
   typedef enum logic [1:0] {RD_ISSUE, RD_AR, RD_R} rd_t;

   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(12'h080);
   localparam logic [pADDR_WIDTH-1:0] LEN_ADDR  = pADDR_WIDTH'(12'h010);
   localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = '0;
   localparam logic [pDATA_WIDTH-1:0] ONE       = pDATA_WIDTH'(1);
   localparam logic [3:0]             LAST_TAP  = 4'(Tape_Num - 1);

   state_t                   state_q, state_d;
   rd_t                      rd_q, rd_d;
   logic [pDATA_WIDTH-1:0]   len_q, len_d;
   logic [pDATA_WIDTH-1:0]   sent_q, sent_d;
   logic [pDATA_WIDTH-1:0]   recv_q, recv_d;
   logic [3:0]               coef_idx_q, coef_idx_d;
   logic                     err_q, err_d;
   logic                     wr_act_q, wr_act_d;
   logic                     awvalid_q, awvalid_d;
   logic                     wvalid_q, wvalid_d;
   logic [pADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                     arvalid_q, arvalid_d;
   logic                     rready_q, rready_d;

   logic in_stream, send_open, recv_open, wr_cmpl, accept;
   logic unused_rdata;

   assign in_stream = (state_q == STREAM);
   assign send_open = in_stream && (sent_q < len_q);
   assign recv_open = in_stream && (recv_q < len_q);
   assign accept    = (state_q == IDLE) && cmd_start && (cmd_len != '0);
   // A write is finished once each channel has either already handshaken or does so now.
   assign wr_cmpl   = wr_act_q && (!awvalid_q || awready) && (!wvalid_q || wready);

   assign ss_tvalid = send_open && x_valid;
   assign x_ready   = send_open && ss_tready;
   assign ss_tdata  = x_data;
   assign ss_tlast  = send_open && (sent_q == len_q - ONE);
   assign sm_tready = recv_open;
   assign y_valid   = sm_tvalid && recv_open;
   assign y_data    = sm_tdata;

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign coef_idx  = coef_idx_q;
   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign awaddr    = awaddr_q;
   assign wdata     = wdata_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign araddr    = CTRL_ADDR;
   assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      len_d      = len_q;
      sent_d     = sent_q;
      recv_d     = recv_q;
      coef_idx_d = coef_idx_q;
      err_d      = err_q;
      wr_act_d   = wr_act_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;

      if (awvalid_q && awready) awvalid_d = 1'b0;
      if (wvalid_q && wready)   wvalid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               if (cmd_len != '0) begin
                  len_d      = cmd_len;
                  err_d      = 1'b0;
                  coef_idx_d = '0;
                  sent_d     = '0;
                  recv_d     = '0;
                  wr_act_d   = 1'b0;
                  state_d    = WR_TAP;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         WR_TAP, WR_LEN, WR_START: begin
            if (!wr_act_q) begin
               wr_act_d  = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               if (state_q == WR_TAP) begin
                  awaddr_d = TAP_BASE + pADDR_WIDTH'({coef_idx_q, 2'b00});
                  wdata_d  = coef_data;
               end else if (state_q == WR_LEN) begin
                  awaddr_d = LEN_ADDR;
                  wdata_d  = len_q;
               end else begin
                  awaddr_d = CTRL_ADDR;
                  wdata_d  = ONE;
               end
            end else if (wr_cmpl) begin
               wr_act_d = 1'b0;
               if (state_q == WR_TAP) begin
                  if (coef_idx_q == LAST_TAP) state_d = WR_LEN;
                  else                        coef_idx_d = coef_idx_q + 4'd1;
               end else if (state_q == WR_LEN) begin
                  state_d = WR_START;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (ss_tvalid && ss_tready) sent_d = sent_q + ONE;
            if (y_valid) begin
               recv_d = recv_q + ONE;
               // tlast must coincide exactly with the final expected beat
               if (sm_tlast != (recv_q == len_q - ONE)) err_d = 1'b1;
            end
            if ((sent_q == len_q) && (recv_q == len_q)) begin
               state_d = POLL;
               rd_d    = RD_ISSUE;
            end
         end
         POLL: begin
            case (rd_q)
               RD_ISSUE: begin
                  arvalid_d = 1'b1;
                  rd_d      = RD_AR;
               end
               RD_AR: begin
                  if (arready) begin
                     arvalid_d = 1'b0;
                     rready_d  = 1'b1;
                     rd_d      = RD_R;
                  end
               end
               RD_R: begin
                  if (rvalid) begin
                     rready_d = 1'b0;
                     rd_d     = RD_ISSUE;
                     if (rdata[1]) state_d = DONE;
                  end
               end
               default: rd_d = RD_ISSUE;
            endcase
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q    <= IDLE;
         rd_q       <= RD_ISSUE;
         len_q      <= '0;
         sent_q     <= '0;
         recv_q     <= '0;
         coef_idx_q <= '0;
         err_q      <= 1'b0;
         wr_act_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         len_q      <= len_d;
         sent_q     <= sent_d;
         recv_q     <= recv_d;
         coef_idx_q <= coef_idx_d;
         err_q      <= err_d;
         wr_act_q   <= wr_act_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
      end
   end

`ifdef FIR_HOST_CHECKSUM_EN
   logic [pDATA_WIDTH-1:0] y_sum_q, y_sum_d;

   always_comb begin
      y_sum_d = y_sum_q;
      if (accept)       y_sum_d = '0;
      else if (y_valid) y_sum_d = y_sum_q + y_data;
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) y_sum_q <= '0;
      else             y_sum_q <= y_sum_d;
   end

   assign y_sum = y_sum_q;
`else
   assign y_sum = '0;
`endif

endmodule

// File: doc/fir_host_ctrl.md
FIR_HOST_CTRL -- requirements
Module: fir_host_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): pADDR_WIDTH, 12, AXI-Lite address width; pDATA_WIDTH, 32, data width; Tape_Num, 11, coefficient count.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first: axis_clk in 1 clock; axis_rst_n in 1 reset. Reset is axis_rst_n, asynchronous, active-low; clock is axis_clk.
REQ-003 Command ports: cmd_start in 1 start pulse; cmd_len in pDATA_WIDTH sample count; busy out 1 high while not IDLE; done out 1 one-cycle completion pulse; err out 1 sticky error, cleared at next accepted cmd_start.
REQ-004 Coefficient source ports: coef_idx out 4 tap index; coef_data in pDATA_WIDTH tap value, combinational from coef_idx.
REQ-005 Sample source ports: x_valid in 1; x_ready out 1; x_data in pDATA_WIDTH.
REQ-006 AXI-Lite master ports: awvalid/wvalid/arvalid/rready out 1; awready/wready/arready/rvalid in 1; awaddr/araddr out pADDR_WIDTH; wdata out pDATA_WIDTH; rdata in pDATA_WIDTH.
REQ-007 Stream ports: ss_tvalid/ss_tlast out 1; ss_tready in 1; ss_tdata out pDATA_WIDTH; sm_tvalid/sm_tlast in 1; sm_tready out 1; sm_tdata in pDATA_WIDTH; y_valid out 1; y_data out pDATA_WIDTH; y_sum out pDATA_WIDTH.

Function
REQ-008 FSM states SHALL be IDLE, WR_TAP, WR_LEN, WR_START, STREAM, POLL, DONE.
REQ-009 IDLE: cmd_start=1 with cmd_len!=0 SHALL latch cmd_len, clear err, and go to WR_TAP; cmd_start with cmd_len==0 SHALL set err, pulse done next cycle, issue no bus traffic; cmd_start outside IDLE SHALL be ignored.
REQ-010 Each AXI-Lite write SHALL assert awvalid and wvalid in the same cycle; each valid SHALL drop independently after its ready is sampled high; the write SHALL complete once both handshakes have occurred (same or different cycles).
REQ-011 WR_TAP SHALL issue Tape_Num writes, write i at awaddr=0x080+4*i with wdata=coef_data and coef_idx=i, i ascending from 0.
REQ-012 WR_LEN SHALL write the latched length to 0x010; WR_START SHALL write 0x00000001 to 0x000.
REQ-013 STREAM: ss_tvalid=x_valid and x_ready=ss_tready while sent<len, else both 0; ss_tdata=x_data; ss_tlast=1 when sent==len-1; sent increments on ss_tvalid&&ss_tready.
REQ-014 STREAM: sm_tready=1 while recv<len, else 0; y_valid=sm_tvalid&&sm_tready, y_data=sm_tdata; recv increments on y_valid.
REQ-015 sm_tlast=1 on an accepted beat with recv!=len-1, or sm_tlast=0 on the beat with recv==len-1, SHALL set err; the beat SHALL still be counted.
REQ-016 STREAM SHALL exit to POLL in the cycle after both sent==len and recv==len.
REQ-017 POLL SHALL read 0x000: arvalid high until arready, then rready high until rvalid; rdata[1]==1 → DONE, else one idle cycle then a new read.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 sent/recv SHALL be pDATA_WIDTH-wide counters; no wrap occurs since both saturate at len.
REQ-020 Outside their states all valid/ready outputs SHALL be 0; addresses/wdata SHALL hold last value.

Reset
REQ-021 Reset SHALL force IDLE; busy, done, err, all valid/ready/tlast outputs, y_sum, counters, coef_idx SHALL be 0; awaddr/araddr/wdata SHALL be 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no completion pulse.

Configuration
REQ-023 With FIR_HOST_CHECKSUM_EN defined, y_sum SHALL clear at accepted cmd_start and add y_data (modulo 2^pDATA_WIDTH) on every y_valid; without it, y_sum SHALL be constant 0 and no adder SHALL exist.

Verification
REQ-024 Taps 0,-10,-9,23,56,63,56,23,-9,-10,0, len=600, ready responder → exactly 11 writes at 0x080..0x0A8, then 0x010←600, then 0x000←1, in order.
REQ-025 Random ss_tready/sm_tvalid gaps, len=600 → 600 ss beats, ss_tlast only on beat 600, 600 y_valid, err=0, done one pulse.
REQ-026 Responder returns rdata=0x0 three times then 0x2 → four reads of 0x000, done after the fourth.
REQ-027 sm_tlast on beat 599 of 600 → err=1 and still 600 beats counted; cmd_len=0 → err=1, done next cycle, no awvalid.
REQ-028 awready delayed 3 cycles after wready → wvalid drops after 1 cycle, awvalid after 4, next write starts afterwards; axis_rst_n low mid-STREAM → all outputs 0, busy=0.
REQ-029 With FIR_HOST_CHECKSUM_EN, y_data 1,2,3 (len=3) → y_sum=6; without the macro → y_sum=0.
